// File: rtl/game_ctrl.sv
// Game sequencer: idle / countdown / running / game-over FSM, tick divider,
// speed ramp, score and high score, and jump/duck command gating.
`timescale 1ns/1ps
module game_ctrl #(
  parameter int unsigned FRAME_DIV       = 550000,
  parameter int unsigned SPEED_INIT      = 100,
  parameter int unsigned SPEED_MAX       = 1000,
  parameter int unsigned SPEED_STEP      = 1,
  parameter int unsigned STEP_TICKS      = 60,
  parameter int unsigned COUNTDOWN_TICKS = 180,
  parameter int unsigned HOLD_TICKS      = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        jump_in,
  input  logic        duck_in,
  input  logic        collision,
  output logic [1:0]  state,
  output logic        runner_rst,
  output logic        game_tick,
  output logic        jump_cmd,
  output logic        duck_cmd,
  output logic [14:0] speed,
  output logic [15:0] score,
  output logic [15:0] hi_score
);

  localparam int unsigned DIV_W    = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned PH_MAX   = (COUNTDOWN_TICKS > HOLD_TICKS) ? COUNTDOWN_TICKS : HOLD_TICKS;
  localparam int unsigned PH_W     = $clog2(PH_MAX + 1);
  localparam int unsigned STEP_W   = $clog2(STEP_TICKS + 1);
  localparam int unsigned HEADROOM = (SPEED_STEP >= SPEED_MAX) ? 0 : SPEED_MAX - SPEED_STEP;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [PH_W-1:0]   PH_CD     = PH_W'(COUNTDOWN_TICKS);
  localparam logic [PH_W-1:0]   PH_HOLD   = PH_W'(HOLD_TICKS);
  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS);
  localparam logic [14:0]       SPD_INIT  = 15'(SPEED_INIT);
  localparam logic [14:0]       SPD_MAX   = 15'(SPEED_MAX);
  localparam logic [14:0]       SPD_HEAD  = 15'(HEADROOM);
  localparam logic [14:0]       SPD_STEP  = 15'(SPEED_STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RUNNING   = 2'd2,
    GAMEOVER  = 2'd3
  } state_t;

  state_t cur_state, nxt_state;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [STEP_W-1:0] step_q, step_d, step_inc;
  logic [14:0]       speed_d;
  logic [15:0]       score_d, hi_d;
  logic              start_q, jump_q;
  logic              start_edge, jump_edge, t;
  logic              tick_d, jump_d, duck_d, runner_rst_d;

  assign state      = cur_state;
  assign t          = (div_q == DIV_LAST);
  assign start_edge = start_btn & ~start_q;
  assign jump_edge  = jump_in & ~jump_q;
  assign step_inc   = step_q + 1'b1;

  always_comb begin
    nxt_state = cur_state;
    div_d     = t ? '0 : div_q + 1'b1;
    phase_d   = phase_q;
    step_d    = step_q;
    speed_d   = speed;
    score_d   = score;
    hi_d      = hi_score;
    tick_d    = 1'b0;
    jump_d    = 1'b0;
    duck_d    = 1'b0;

    case (cur_state)
      IDLE: begin
        if (start_edge) begin
          nxt_state = COUNTDOWN;
          phase_d   = PH_CD;
          score_d   = '0;
          step_d    = '0;
          speed_d   = SPD_INIT;
          div_d     = '0;
        end
      end
      COUNTDOWN: begin
        if (t) begin
          phase_d = phase_q - 1'b1;
          if (phase_q == PH_ONE) nxt_state = RUNNING;
        end
      end
      RUNNING: begin
        // hi_score tracks the registered score, so it trails by one cycle
        if (score > hi_score) hi_d = score;
        if (collision) begin
          nxt_state = GAMEOVER;
          phase_d   = PH_HOLD;
        end else begin
          if (t) begin
            tick_d = 1'b1;
            if (score != '1) score_d = score + 16'd1;
            if (step_inc >= STEP_LAST) begin
              step_d  = '0;
              speed_d = (speed >= SPD_HEAD) ? SPD_MAX : speed + SPD_STEP;
            end else begin
              step_d = step_inc;
            end
          end
          jump_d = jump_edge;
          duck_d = duck_in & ~jump_edge;
        end
      end
      GAMEOVER: begin
        if (start_edge && phase_q == '0) begin
          nxt_state = COUNTDOWN;
          phase_d   = PH_CD;
          score_d   = '0;
          step_d    = '0;
          speed_d   = SPD_INIT;
          div_d     = '0;
        end else if (t && phase_q != '0) begin
          phase_d = phase_q - 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    runner_rst_d = (nxt_state == IDLE) || (nxt_state == COUNTDOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= IDLE;
      div_q      <= '0;
      phase_q    <= '0;
      step_q     <= '0;
      speed      <= SPD_INIT;
      score      <= '0;
      hi_score   <= '0;
      start_q    <= 1'b0;
      jump_q     <= 1'b0;
      game_tick  <= 1'b0;
      jump_cmd   <= 1'b0;
      duck_cmd   <= 1'b0;
      runner_rst <= 1'b1;
    end else begin
      cur_state  <= nxt_state;
      div_q      <= div_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      speed      <= speed_d;
      score      <= score_d;
      hi_score   <= hi_d;
      start_q    <= start_btn;
      jump_q     <= jump_in;
      game_tick  <= tick_d;
      jump_cmd   <= jump_d;
      duck_cmd   <= duck_d;
      runner_rst <= runner_rst_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a rule-level model predicts every output
// each cycle; a monitor pops and compares, plus directed spot checks.
`timescale 1ns/1ps
module tb_game_ctrl;
  localparam int FD = 4, ST = 3, CD = 2, HT = 2, SI = 10, SM = 12, SS = 1;

  logic clk = 1'b0;
  logic rst, start_btn, jump_in, duck_in, collision;
  logic [1:0]  state;
  logic        runner_rst, game_tick, jump_cmd, duck_cmd;
  logic [14:0] speed;
  logic [15:0] score, hi_score;

  game_ctrl #(
    .FRAME_DIV(FD), .SPEED_INIT(SI), .SPEED_MAX(SM), .SPEED_STEP(SS),
    .STEP_TICKS(ST), .COUNTDOWN_TICKS(CD), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .jump_in(jump_in),
    .duck_in(duck_in), .collision(collision), .state(state),
    .runner_rst(runner_rst), .game_tick(game_tick), .jump_cmd(jump_cmd),
    .duck_cmd(duck_cmd), .speed(speed), .score(score), .hi_score(hi_score)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due; int st; int rr; int tk; int jc; int dc; int sp; int sc; int hi;
  } exp_t;
  exp_t sbq[$];

  // Reference model state: mode 0..3 and plain integer counters
  int m_st, m_div, m_ph, m_step, m_sp, m_sc, m_hi, m_sprev, m_jprev;
  int m_tk, m_jc, m_dc, m_rr;

  function automatic void new_game();
    m_ph = CD; m_sc = 0; m_sp = SI; m_step = 0; m_div = 0;
  endfunction

  function automatic void model_step(input bit r, input bit sb, input bit ji,
                                     input bit di, input bit co);
    bit t, se, je;
    int ns;
    if (r) begin
      m_st = 0; m_div = 0; m_ph = 0; m_step = 0; m_sp = SI; m_sc = 0; m_hi = 0;
      m_sprev = 0; m_jprev = 0; m_tk = 0; m_jc = 0; m_dc = 0; m_rr = 1;
      return;
    end
    t  = (m_div == FD - 1);
    se = sb && (m_sprev == 0);
    je = ji && (m_jprev == 0);
    m_sprev = sb; m_jprev = ji;
    m_tk = 0; m_jc = 0; m_dc = 0;
    m_div = t ? 0 : m_div + 1;
    ns = m_st;
    case (m_st)
      0: if (se) begin ns = 1; new_game(); end
      1: if (t) begin
           if (m_ph == 1) ns = 2;
           m_ph = m_ph - 1;
         end
      2: begin
           if (m_sc > m_hi) m_hi = m_sc;
           if (co) begin
             ns = 3; m_ph = HT;
           end else begin
             if (t) begin
               m_tk = 1;
               if (m_sc < 65535) m_sc = m_sc + 1;
               m_step = m_step + 1;
               if (m_step == ST) begin
                 m_step = 0;
                 m_sp = (m_sp + SS > SM) ? SM : m_sp + SS;
               end
             end
             m_jc = je;
             m_dc = (di && !je) ? 1 : 0;
           end
         end
      default: begin
           if (se && m_ph == 0) begin ns = 1; new_game(); end
           else if (t && m_ph > 0) m_ph = m_ph - 1;
         end
    endcase
    m_st = ns;
    m_rr = (ns <= 1) ? 1 : 0;
  endfunction

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic drive(input bit r, input bit sb, input bit ji, input bit di, input bit co);
    exp_t e;
    rst = r; start_btn = sb; jump_in = ji; duck_in = di; collision = co;
    model_step(r, sb, ji, di, co);
    e.due = cyc + 1; e.st = m_st; e.rr = m_rr; e.tk = m_tk; e.jc = m_jc;
    e.dc = m_dc; e.sp = m_sp; e.sc = m_sc; e.hi = m_hi;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check("sb_state",      int'(state),      e.st);
        check("sb_runner_rst", int'(runner_rst), e.rr);
        check("sb_game_tick",  int'(game_tick),  e.tk);
        check("sb_jump_cmd",   int'(jump_cmd),   e.jc);
        check("sb_duck_cmd",   int'(duck_cmd),   e.dc);
        check("sb_speed",      int'(speed),      e.sp);
        check("sb_score",      int'(score),      e.sc);
        check("sb_hi_score",   int'(hi_score),   e.hi);
      end
    end
  end

  initial begin
    bit r, sb, ji, di, co;
    int n;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("rst_state", state, 0);
    check("rst_runner_rst", runner_rst, 1);
    check("rst_speed", speed, SI);

    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    check("idle_jump", jump_cmd, 0);
    drive(0, 0, 0, 0, 0);

    // start held: one transition, countdown lasts 8 cycles
    drive(0, 1, 0, 0, 0);
    check("cd_state", state, 1);
    check("cd_runner_rst", runner_rst, 1);
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 0, 0);
    check("cd_still", state, 1);
    drive(0, 1, 0, 0, 0);
    check("run_state", state, 2);
    check("run_runner_rst", runner_rst, 0);

    for (n = 0; n < 200 && m_sc < 9; n++) drive(0, 0, 0, 0, 0);
    check("wait_score9", (m_sc == 9) ? 1 : 0, 1);
    check("score9", score, 9);
    check("speed_sat", speed, SM);

    // fresh game, collide together with the 6th tick
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (n = 0; n < 200 && !(m_st == 2 && m_sc == 5 && m_div == FD - 1); n++)
      drive(0, 0, 0, 0, 0);
    check("wait_score5", (m_st == 2 && m_sc == 5) ? 1 : 0, 1);
    drive(0, 0, 0, 0, 1);
    check("go_state", state, 3);
    check("go_score", score, 5);
    check("go_tick", game_tick, 0);
    check("go_speed", speed, 11);
    check("go_hi", hi_score, 5);
    drive(0, 0, 0, 0, 0);

    for (n = 0; n < 50 && m_ph != 1; n++) drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("go_start_ignored", state, 3);
    drive(0, 0, 0, 0, 0);
    for (n = 0; n < 50 && m_ph != 0; n++) drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("restart_state", state, 1);
    check("restart_score", score, 0);
    check("restart_speed", speed, SI);
    check("restart_hi", hi_score, 5);
    drive(0, 0, 0, 0, 0);
    for (n = 0; n < 200 && !(m_st == 2 && m_sc == 3); n++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    check("hi_kept", hi_score, 5);

    // jump/duck priority and single pulse on held jump
    for (n = 0; n < 50 && m_ph != 0; n++) drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (n = 0; n < 200 && m_st != 2; n++) drive(0, 0, 0, 0, 0);
    check("wait_run2", m_st, 2);
    drive(0, 0, 1, 1, 0);
    check("jd_jump", jump_cmd, 1);
    check("jd_duck", duck_cmd, 0);
    drive(0, 0, 1, 1, 0);
    check("jd_jump_off", jump_cmd, 0);
    check("jd_duck_on", duck_cmd, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0);

    // reset mid-run
    for (n = 0; n < 200 && m_sc < 7; n++) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_runner_rst", runner_rst, 1);
    check("mid_rst_speed", speed, SI);
    check("mid_rst_score", score, 0);
    check("mid_rst_hi", hi_score, 0);
    check("mid_rst_pulses", {game_tick, jump_cmd, duck_cmd}, 0);

    sb = 0; ji = 0; di = 0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 9) == 0) sb = ~sb;
      if ($urandom_range(0, 3) == 0) ji = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) di = 1'($urandom_range(0, 1));
      co = ($urandom_range(0, 59) == 0);
      drive(r, sb, ji, di, co);
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
